uart_tx_ctrl: RTL and testbench

- Memory-mapped transmit controller that sequences the `uart_tx` serializer.
- Replaces the free-running "send 0x68 whenever ready" logic at top level.
- Snoops the CPU data-memory write port, queues bytes written to a TX data address in a byte FIFO, and issues one `start`/`tbus` handshake per byte to `uart_tx`.
- Exposes level/status outputs for the mem block's readback mux.

---
 rtl/jpeb_uart_pkg.sv | 17 +
 rtl/byte_fifo.sv | 83 ++++++++
 rtl/uart_tx_ctrl.sv | 134 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeb_uart_pkg.sv
// Shared definitions for the UART transmit controller and the memory readback decode.
package jpeb_uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

  localparam logic [15:0] TX_DATA_ADDR_DEFAULT = 16'hFFF0;
  localparam logic [15:0] TX_CTRL_ADDR_DEFAULT = 16'hFFF1;

  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead synchronous FIFO; pushes into a full FIFO and pops from an empty one are ignored.
module byte_fifo
  import jpeb_uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_q == FULL_LEVEL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer, level and storage updates; flush discards everything queued and wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers are cleared by reset; data storage needs no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array register.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped transmit controller: snoops CPU writes, queues bytes, and hands them one at a
// time to the uart_tx serializer with a start pulse, retrying if the serializer never reacts.
module uart_tx_ctrl
  import jpeb_uart_pkg::*;
#(
  parameter int          DEPTH        = 16,
  parameter logic [15:0] TX_DATA_ADDR = TX_DATA_ADDR_DEFAULT,
  parameter logic [15:0] TX_CTRL_ADDR = TX_CTRL_ADDR_DEFAULT,
  parameter int          ACK_TIMEOUT  = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wen,
  input  logic [15:0]              waddr,
  input  logic [15:0]              wdata,
  input  logic                     tx_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_bus,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     overflow,
  output logic                     busy
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(ACK_TIMEOUT);

  tx_state_e     state_q, state_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_bus_q, tx_bus_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          overflow_q, overflow_d;
  logic          data_wr;
  logic          ctrl_wr;
  logic          flush;
  logic          pop;
  logic [7:0]    fifo_dout;
  logic          unused_wdata_hi;

  assign data_wr         = wen && (waddr == TX_DATA_ADDR);
  assign ctrl_wr         = wen && (waddr == TX_CTRL_ADDR);
  assign flush           = ctrl_wr && wdata[CTRL_FLUSH_BIT];
  assign unused_wdata_hi = ^wdata[15:8];

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (data_wr),
    .pop   (pop),
    .flush (flush),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow: set when a data write meets a full FIFO, cleared by a control write.
  always_comb begin
    overflow_d = overflow_q;
    if (data_wr && fifo_full) begin
      overflow_d = 1'b1;
    end else if (ctrl_wr && wdata[CTRL_CLR_OVF_BIT]) begin
      overflow_d = 1'b0;
    end
  end

  // Handshake sequencing: launch a byte, wait for the serializer to go busy (retrying on timeout),
  // then wait for it to finish before looking at the FIFO again.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_bus_d   = tx_bus_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && tx_ready) begin
          tx_bus_d   = fifo_dout;
          pop        = 1'b1;
          tx_start_d = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!tx_ready) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_MAX) begin
          tx_start_d = 1'b1;
          state_d    = START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_bus_q   <= 8'h00;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_bus_q   <= tx_bus_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_bus   = tx_bus_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed scenarios plus a randomized phase, checked every
// cycle against a queue-based reference model and a behavioural serializer.
module tb_uart_tx_ctrl;

  localparam int          DEPTH       = 16;
  localparam int          ACK_TIMEOUT = 1023;
  localparam int          LW          = $clog2(DEPTH) + 1;
  localparam logic [15:0] DATA_ADDR   = 16'hFFF0;
  localparam logic [15:0] CTRL_ADDR   = 16'hFFF1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wen = 1'b0;
  logic [15:0]   waddr = 16'h0000;
  logic [15:0]   wdata = 16'h0000;
  logic          tx_ready = 1'b1;
  logic          tx_start;
  logic [7:0]    tx_bus;
  logic [LW-1:0] fifo_level;
  logic          fifo_full;
  logic          fifo_empty;
  logic          overflow;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference model: queued bytes, sticky overflow, and transfer phase
  // (0 = no transfer, 1 = started but not yet acknowledged, 2 = serializer busy).
  byte unsigned mQueue[$];
  bit           mOverflow = 1'b0;
  int           mPhase = 0;
  int           mSinceStart = 0;
  logic [7:0]   mBus = 8'h00;

  // Serializer model and observation records.
  bit  serAuto = 1'b1;
  int  serPhase = 0;
  int  serDly = 0;
  int  serLen = 0;
  int  serDlyMin = 0;
  int  serDlyMax = 0;
  int  serLenMin = 10;
  int  serLenMax = 10;
  int  edgeCount = 0;
  int  startCount = 0;
  int  startEdges[$];
  byte unsigned sent[$];

  // Free-running system clock.
  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .DEPTH        (DEPTH),
    .TX_DATA_ADDR (DATA_ADDR),
    .TX_CTRL_ADDR (CTRL_ADDR),
    .ACK_TIMEOUT  (ACK_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .tx_ready   (tx_ready),
    .tx_start   (tx_start),
    .tx_bus     (tx_bus),
    .fifo_level (fifo_level),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow),
    .busy       (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edgeCount);
    end
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, compare all outputs,
  // then let the serializer model react.
  task automatic cycle();
    bit doPop;
    bit wasFull;
    @(posedge clk);
    edgeCount++;
    doPop = 1'b0;
    if (reset) begin
      mQueue.delete();
      mOverflow   = 1'b0;
      mPhase      = 0;
      mSinceStart = 0;
      mBus        = 8'h00;
    end else begin
      wasFull = (mQueue.size() == DEPTH);
      case (mPhase)
        0: begin
          if (mQueue.size() != 0 && tx_ready) begin
            mBus        = mQueue[0];
            doPop       = 1'b1;
            mPhase      = 1;
            mSinceStart = 0;
          end
        end
        1: begin
          if (mSinceStart == 0) mSinceStart = 1;
          else if (!tx_ready) mPhase = 2;
          else if (mSinceStart == ACK_TIMEOUT + 1) mSinceStart = 0;
          else mSinceStart++;
        end
        default: begin
          if (tx_ready) mPhase = 0;
        end
      endcase
      if (doPop) void'(mQueue.pop_front());
      if (wen && waddr == DATA_ADDR) begin
        if (wasFull) mOverflow = 1'b1;
        else mQueue.push_back(wdata[7:0]);
      end
      if (wen && waddr == CTRL_ADDR) begin
        if (wdata[0]) mQueue.delete();
        if (wdata[1]) mOverflow = 1'b0;
      end
    end
    #1;
    checkOutput("tx_start", tx_start, (mPhase == 1 && mSinceStart == 0));
    checkOutput("tx_bus", tx_bus, mBus);
    checkOutput("fifo_level", fifo_level, mQueue.size());
    checkOutput("fifo_full", fifo_full, (mQueue.size() == DEPTH));
    checkOutput("fifo_empty", fifo_empty, (mQueue.size() == 0));
    checkOutput("overflow", overflow, mOverflow);
    checkOutput("busy", busy, (mPhase != 0 || mQueue.size() != 0));
    if (tx_start === 1'b1) begin
      startCount++;
      startEdges.push_back(edgeCount);
    end
    if (doPop) sent.push_back(tx_bus);
    if (serAuto) begin
      if (serPhase == 0 && tx_start === 1'b1) begin
        serDly   = $urandom_range(serDlyMax, serDlyMin);
        serLen   = $urandom_range(serLenMax, serLenMin);
        serPhase = 1;
      end
      if (serPhase == 1) begin
        if (serDly == 0) begin
          tx_ready = 1'b0;
          serPhase = 2;
        end else begin
          serDly--;
        end
      end else if (serPhase == 2) begin
        if (serLen <= 1) begin
          tx_ready = 1'b1;
          serPhase = 0;
        end else begin
          serLen--;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [15:0] addr, input logic [15:0] data);
    wen   = w;
    waddr = addr;
    wdata = data;
    cycle();
    wen   = 1'b0;
    waddr = 16'h0000;
    wdata = 16'h0000;
  endtask

  task automatic runUntilIdle(input int maxCycles, input string tag);
    int n = 0;
    while ((busy !== 1'b0 || serPhase != 0) && n < maxCycles) begin
      cycle();
      n++;
    end
    checkOutput(tag, (n < maxCycles), 1);
  endtask

  initial begin
    int wrEdge;
    int startsBefore;
    int r;

    $display("[TB] reset");
    reset = 1'b1;
    repeat (3) cycle();
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_empty", fifo_empty, 1);
    checkOutput("rst_start", tx_start, 0);
    reset = 1'b0;
    cycle();

    $display("[TB] single byte latency");
    startEdges.delete();
    applyStimulus(1'b1, DATA_ADDR, 16'h0141);
    wrEdge = edgeCount;
    cycle();
    checkOutput("t1_start_high", tx_start, 1);
    checkOutput("t1_bus", tx_bus, 8'h41);
    cycle();
    checkOutput("t1_start_one_cycle", tx_start, 0);
    runUntilIdle(60, "t1_drain_timeout");
    checkOutput("t1_start_count", startEdges.size(), 1);
    if (startEdges.size() > 0) checkOutput("t1_latency", startEdges[0] - wrEdge, 1);
    checkOutput("t1_busy", busy, 0);
    checkOutput("t1_empty", fifo_empty, 1);

    $display("[TB] fill to overflow with serializer held busy");
    serAuto  = 1'b0;
    serPhase = 0;
    tx_ready = 1'b0;
    cycle();
    startsBefore = startCount;
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, DATA_ADDR, 16'(i));
    cycle();
    checkOutput("t2_level", fifo_level, 16);
    checkOutput("t2_full", fifo_full, 1);
    checkOutput("t2_overflow", overflow, 1);
    checkOutput("t2_no_start", startCount - startsBefore, 0);
    sent.delete();
    serAuto   = 1'b1;
    serDlyMin = 0;
    serDlyMax = 3;
    serLenMin = 3;
    serLenMax = 8;
    tx_ready  = 1'b1;
    runUntilIdle(800, "t2_drain_timeout");
    checkOutput("t2_sent_count", sent.size(), 16);
    for (int i = 0; i < 16 && i < sent.size(); i++) checkOutput("t2_sent_order", sent[i], i);
    checkOutput("t2_level_end", fifo_level, 0);

    $display("[TB] overflow clear and flush with a byte in flight");
    applyStimulus(1'b1, CTRL_ADDR, 16'h0002);
    checkOutput("t3_ovf_clear", overflow, 0);
    serDlyMin = 0;
    serDlyMax = 0;
    serLenMin = 40;
    serLenMax = 40;
    sent.delete();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, DATA_ADDR, 16'h00A0 + 16'(i));
    checkOutput("t3_level_before", fifo_level, 5);
    checkOutput("t3_busy_before", busy, 1);
    startsBefore = startCount;
    applyStimulus(1'b1, CTRL_ADDR, 16'h0001);
    checkOutput("t3_level_flushed", fifo_level, 0);
    checkOutput("t3_busy_inflight", busy, 1);
    runUntilIdle(120, "t3_drain_timeout");
    repeat (10) cycle();
    checkOutput("t3_no_more_starts", startCount - startsBefore, 0);
    checkOutput("t3_sent_count", sent.size(), 1);
    if (sent.size() > 0) checkOutput("t3_sent_byte", sent[0], 8'hA0);

    $display("[TB] ack timeout retry");
    serAuto  = 1'b0;
    serPhase = 0;
    tx_ready = 1'b1;
    startEdges.delete();
    sent.delete();
    applyStimulus(1'b1, DATA_ADDR, 16'h00A5);
    applyStimulus(1'b1, DATA_ADDR, 16'h005A);
    repeat (3 * (ACK_TIMEOUT + 2) + 2) cycle();
    checkOutput("t4_retry_count", startEdges.size(), 4);
    for (int i = 1; i < startEdges.size(); i++)
      checkOutput("t4_retry_period", startEdges[i] - startEdges[i-1], ACK_TIMEOUT + 2);
    checkOutput("t4_no_pop", fifo_level, 1);
    checkOutput("t4_same_bus", tx_bus, 8'hA5);
    serAuto   = 1'b1;
    serDlyMin = 0;
    serDlyMax = 3;
    serLenMin = 3;
    serLenMax = 8;
    runUntilIdle(ACK_TIMEOUT + 200, "t4_drain_timeout");
    checkOutput("t4_sent_count", sent.size(), 2);
    if (sent.size() == 2) begin
      checkOutput("t4_sent0", sent[0], 8'hA5);
      checkOutput("t4_sent1", sent[1], 8'h5A);
    end

    $display("[TB] reset during transfer");
    serDlyMin = 0;
    serDlyMax = 0;
    serLenMin = 60;
    serLenMax = 60;
    sent.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, DATA_ADDR, 16'h00C0 + 16'(i));
    repeat (2) cycle();
    checkOutput("t5_level_queued", fifo_level, 3);
    checkOutput("t5_ready_low", tx_ready, 0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checkOutput("t5_rst_start", tx_start, 0);
    checkOutput("t5_rst_bus", tx_bus, 0);
    checkOutput("t5_rst_level", fifo_level, 0);
    checkOutput("t5_rst_empty", fifo_empty, 1);
    checkOutput("t5_rst_busy", busy, 0);
    startsBefore = startCount;
    applyStimulus(1'b1, DATA_ADDR, 16'h00D1);
    applyStimulus(1'b1, DATA_ADDR, 16'h00D2);
    repeat (10) cycle();
    checkOutput("t5_no_start_while_busy", startCount - startsBefore, 0);
    checkOutput("t5_level_waiting", fifo_level, 2);
    runUntilIdle(300, "t5_drain_timeout");
    checkOutput("t5_sent_count", sent.size(), 3);
    if (sent.size() == 3) begin
      checkOutput("t5_sent0", sent[0], 8'hC0);
      checkOutput("t5_sent1", sent[1], 8'hD1);
      checkOutput("t5_sent2", sent[2], 8'hD2);
    end

    $display("[TB] ignored writes");
    startsBefore = startCount;
    applyStimulus(1'b1, 16'hFFF2, 16'h0055);
    applyStimulus(1'b0, DATA_ADDR, 16'h0066);
    repeat (5) cycle();
    checkOutput("t6_level", fifo_level, 0);
    checkOutput("t6_no_start", startCount - startsBefore, 0);

    $display("[TB] randomized traffic");
    serDlyMin = 0;
    serDlyMax = 3;
    serLenMin = 2;
    serLenMax = 12;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(99, 0);
      if (r < 45) applyStimulus(1'b1, DATA_ADDR, 16'($urandom));
      else if (r < 49) applyStimulus(1'b1, CTRL_ADDR, 16'($urandom_range(3, 0)));
      else if (r < 52) applyStimulus(1'b1, 16'($urandom), 16'($urandom));
      else if (r < 55) applyStimulus(1'b0, DATA_ADDR, 16'($urandom));
      else cycle();
    end
    runUntilIdle(800, "rand_drain_timeout");
    checkOutput("rand_empty_end", fifo_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
